// File: rtl/dmem_pkg.sv
// Shared constants for the sub-word data memory: size codes, FSM states, lane geometry.
package dmem_pkg;

   localparam int unsigned LANE_W = 8;
   localparam int unsigned WORD_W = 4 * LANE_W;

   // Access size encodings carried on req_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Access FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: merges store data into the old word, extracts and
// extends load data, and flags misaligned or reserved-size accesses.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [WORD_W-1:0] old_word_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [1:0]        addr_lo_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   output logic [WORD_W-1:0] st_word_o,
   output logic [WORD_W-1:0] ld_word_o,
   output logic              misalign_o
);

   logic [LANE_W-1:0]   byte_v;
   logic [2*LANE_W-1:0] half_v;
   logic                byte_sx;
   logic                half_sx;

   assign byte_v  = old_word_i[LANE_W*addr_lo_i +: LANE_W];
   assign half_v  = old_word_i[2*LANE_W*addr_lo_i[1] +: 2*LANE_W];
   assign byte_sx = byte_v[LANE_W-1] & ~unsigned_i;
   assign half_sx = half_v[2*LANE_W-1] & ~unsigned_i;

   // Decode size into store merge, load extension and alignment check
   always_comb begin
      st_word_o  = old_word_i;
      ld_word_o  = '0;
      misalign_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            st_word_o[LANE_W*addr_lo_i +: LANE_W] = wdata_i[LANE_W-1:0];
            ld_word_o = {{(WORD_W-LANE_W){byte_sx}}, byte_v};
         end
         SZ_HALF: begin
            st_word_o[2*LANE_W*addr_lo_i[1] +: 2*LANE_W] = wdata_i[2*LANE_W-1:0];
            ld_word_o  = {{(WORD_W-2*LANE_W){half_sx}}, half_v};
            misalign_o = addr_lo_i[0];
         end
         SZ_WORD: begin
            st_word_o  = wdata_i;
            ld_word_o  = old_word_i;
            misalign_o = (addr_lo_i != 2'b00);
         end
         default: begin
            // Reserved size is reported through the same error path as misalignment
            misalign_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_subword.sv
// MEM-stage data memory with MIPS sub-word access, fixed access latency and a
// valid/ready request handshake. Bad accesses report err instead of touching memory.
module data_mem_subword
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam int unsigned   IW      = ADDR_W - 2;
   localparam int unsigned   MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);
   localparam logic [2:0]    LAT_M1  = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              accept;
   logic              commit;
   logic              mem_we;
   logic              a_we;
   logic [1:0]        a_size;
   logic              a_uns;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [IW-1:0]     a_widx;
   logic [MW-1:0]     a_idx;
   logic              a_oor;
   logic              a_misalign;
   logic              a_err;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] st_word;
   logic [DATA_W-1:0] ld_word;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign accept     = req_valid && req_ready;

   // Next-state and wait-counter sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the request fields on acceptance
   always_comb begin
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (accept) begin
         we_d    = req_we;
         size_d  = req_size;
         uns_d   = req_unsigned;
         addr_d  = addr;
         wdata_d = wdata;
      end
   end

   // With zero latency the access happens on the accept edge, so use the live request
   always_comb begin
      if (state_q == ST_IDLE) begin
         a_we    = req_we;
         a_size  = req_size;
         a_uns   = req_unsigned;
         a_addr  = addr;
         a_wdata = wdata;
      end else begin
         a_we    = we_q;
         a_size  = size_q;
         a_uns   = uns_q;
         a_addr  = addr_q;
         a_wdata = wdata_q;
      end
   end

   assign a_widx   = a_addr[ADDR_W-1:2];
   assign a_oor    = (a_widx >= DEPTH_W);
   assign a_idx    = a_addr[MW+1:2];
   assign old_word = mem_q[a_idx];
   assign a_err    = a_misalign | a_oor;
   assign commit   = (state_d == ST_RESP) && (state_q != ST_RESP);
   // rst_n gate keeps a zero-latency accept from writing while reset is held
   assign mem_we   = commit && a_we && !a_err && rst_n;

   dmem_lane_align u_align (
      .old_word_i (old_word),
      .wdata_i    (a_wdata),
      .addr_lo_i  (a_addr[1:0]),
      .size_i     (a_size),
      .unsigned_i (a_uns),
      .st_word_o  (st_word),
      .ld_word_o  (ld_word),
      .misalign_o (a_misalign)
   );

   // Response data and error register on the edge entering RESP, then hold
   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = a_err;
         rdata_d = (a_err || a_we) ? '0 : ld_word;
      end
   end

   // Control and request state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[a_idx] <= st_word;
      end
   end

endmodule

// File: tb/tb_data_mem_subword.sv
// Bench for data_mem_subword: dut0 has LATENCY=1, dut1 has LATENCY=0. A byte-level
// reference model predicts handshake, timing and data; directed literals pin the model.
module tb_data_mem_subword;

   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we [2];
   logic [1:0]  req_size [2];
   logic        req_unsigned [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        resp_valid [2];
   logic [31:0] rdata [2];
   logic        err [2];

   int n_checks = 0;
   int n_fail = 0;
   bit cmp_on = 1'b0;

   data_mem_subword #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .addr(addr[0]), .wdata(wdata[0]), .resp_valid(resp_valid[0]), .rdata(rdata[0]),
      .err(err[0])
   );

   data_mem_subword #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .addr(addr[1]), .wdata(wdata[1]), .resp_valid(resp_valid[1]), .rdata(rdata[1]),
      .err(err[1])
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_mem [2][DEPTH];
   bit          m_busy [2];
   int          m_age [2];
   bit          m_we [2];
   logic [1:0]  m_size [2];
   bit          m_uns [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdata [2];
   bit          exp_ready [2];
   bit          exp_resp [2];
   logic [31:0] exp_rdata [2];
   bit          exp_err [2];

   task automatic model_access(input int k);
      int unsigned nb, off, w;
      logic [31:0] word, mask, v;
      bit e;
      nb = (m_size[k] == 2'd0) ? 1 : (m_size[k] == 2'd1) ? 2 : 4;
      off = m_addr[k] % 4;
      e = (m_size[k] == 2'd3) || ((m_addr[k] % nb) != 0) || ((m_addr[k] / 4) >= DEPTH);
      exp_err[k] = e;
      exp_rdata[k] = 32'h0;
      if (!e) begin
         w = m_addr[k] / 4;
         word = m_mem[k][w];
         mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
         if (m_we[k]) begin
            word = (word & ~(mask << (8 * off))) | ((m_wdata[k] & mask) << (8 * off));
            m_mem[k][w] = word;
         end else begin
            v = (word >> (8 * off)) & mask;
            if (!m_uns[k] && nb != 4 && v[8*nb-1]) v = v | ~mask;
            exp_rdata[k] = v;
         end
      end
   endtask

   initial begin
      bit wb;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0; m_age[k] = 0; exp_ready[k] = 1'b1; exp_resp[k] = 1'b0;
         exp_rdata[k] = 32'h0; exp_err[k] = 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) m_mem[k][i] = 32'h0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               m_busy[k] = 1'b0; exp_ready[k] = 1'b1; exp_resp[k] = 1'b0;
               exp_rdata[k] = 32'h0; exp_err[k] = 1'b0;
            end else begin
               wb = m_busy[k];
               if (m_busy[k]) begin
                  m_age[k]++;
                  if (m_age[k] > lat_of(k)) m_busy[k] = 1'b0;
               end
               if (!wb && req_valid[k]) begin
                  m_busy[k] = 1'b1; m_age[k] = 0;
                  m_we[k] = req_we[k]; m_size[k] = req_size[k]; m_uns[k] = req_unsigned[k];
                  m_addr[k] = addr[k]; m_wdata[k] = wdata[k];
               end
               exp_resp[k] = m_busy[k] && (m_age[k] == lat_of(k));
               if (exp_resp[k]) model_access(k);
               exp_ready[k] = !m_busy[k];
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk32(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input int k, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %b expected %b at %0t", name, k, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   initial begin
      wait (cmp_on);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk1("ready", k, req_ready[k], exp_ready[k]);
            chk1("resp_valid", k, resp_valid[k], exp_resp[k]);
            if (exp_resp[k]) begin
               chk32("rdata", k, rdata[k], exp_rdata[k]);
               chk1("err", k, err[k], exp_err[k]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   // Called just after a rising edge; returns just after the accepting edge
   task automatic issue(input int k, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
      int guard;
      guard = 0;
      req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = sz; req_unsigned[k] = uns;
      addr[k] = a; wdata[k] = wd;
      while (req_ready[k] !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout dut%0d: got no ready expected ready within 50", k);
      end
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
   endtask

   task automatic get_resp(input int k, output logic [31:0] rd, output logic e, output int lat);
      lat = 0;
      while (resp_valid[k] !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      rd = rdata[k]; e = err[k];
      if (resp_valid[k] !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout dut%0d: got no resp_valid expected one within 20", k);
      end
   endtask

   task automatic access(input string name, input int k, input bit we, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_e);
      logic [31:0] rd;
      logic e;
      int lat;
      issue(k, we, sz, uns, a, wd);
      get_resp(k, rd, e, lat);
      chk32({name, "_rdata"}, k, rd, exp_rd);
      chk1({name, "_err"}, k, e, exp_e);
      chk32({name, "_lat"}, k, 32'(lat), 32'(lat_of(k)));
      @(posedge clk); #1;
   endtask

   task automatic rand_run(input int k, input int n);
      bit we, uns;
      logic [1:0] sz;
      logic [31:0] a;
      int r;
      for (int i = 0; i < n; i++) begin
         we = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 15));
         sz = (r == 15) ? 2'd3 : 2'(r % 3);
         r = int'($urandom_range(0, 15));
         if (r == 0) a = 4 * DEPTH + $urandom_range(0, 15);
         else if (r == 1) a = $urandom;
         else a = $urandom_range(0, 127);
         issue(k, we, sz, uns, a, $urandom);
         // Half the time the next request is presented at once and held while busy
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'd0; req_unsigned[k] = 1'b0;
         addr[k] = 32'h0; wdata[k] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cmp_on = 1'b1;
      @(posedge clk); #1;

      chk1("rst_ready", 0, req_ready[0], 1'b1);
      chk1("rst_resp", 0, resp_valid[0], 1'b0);
      chk32("rst_rdata", 0, rdata[0], 32'h0);
      chk1("rst_err", 0, err[0], 1'b0);

      // word store/load
      access("sw10", 0, 1, 2'd2, 0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      access("lw10", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
      // byte merge and extension
      access("sb11", 0, 1, 2'd0, 0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0);
      access("lw10b", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_AB78, 1'b0);
      access("lb11", 0, 0, 2'd0, 0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
      access("lbu11", 0, 0, 2'd0, 1, 32'h11, 32'h0, 32'h0000_00AB, 1'b0);
      // half merge and extension
      access("sh22", 0, 1, 2'd1, 0, 32'h22, 32'h5555_8001, 32'h0, 1'b0);
      access("lw20", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001_0000, 1'b0);
      access("lh22", 0, 0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
      access("lhu22", 0, 0, 2'd1, 1, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
      // errors
      access("lw13", 0, 0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1'b1);
      access("sh21", 0, 1, 2'd1, 0, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1);
      access("lw20u", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001_0000, 1'b0);
      access("lw_oor", 0, 0, 2'd2, 0, 4 * DEPTH, 32'h0, 32'h0, 1'b1);
      access("sw_oor", 0, 1, 2'd2, 0, 4 * DEPTH + 32'h10, 32'h1, 32'h0, 1'b1);
      access("lw_0", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_AB78, 1'b0);
      access("rsvd", 0, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1'b1);
      // zero-latency instance
      access("sw08_l0", 1, 1, 2'd2, 0, 32'h08, 32'hCAFE_F00D, 32'h0, 1'b0);
      access("lw08_l0", 1, 0, 2'd2, 0, 32'h08, 32'h0, 32'hCAFE_F00D, 1'b0);
      access("lb09_l0", 1, 0, 2'd0, 0, 32'h09, 32'h0, 32'hFFFF_FFF0, 1'b0);

      // reset while a store waits
      issue(0, 1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk1("rstw_resp", 0, resp_valid[0], 1'b0);
         chk1("rstw_ready", 0, req_ready[0], 1'b1);
      end
      chk32("rstw_rdata", 0, rdata[0], 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      access("lw40", 0, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1'b0);

      // randomized traffic on both instances
      fork
         rand_run(0, 200);
         rand_run(1, 200);
      join
      repeat (6) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
